// File: rtl/hk_pkg.sv
// hk_pkg: shared FSM state type and sizing constants for the housekeeping SRAM dump.
package hk_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, EMIT, DONE} hk_state_t;
  localparam int SRAM_WORDS = 256;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/hk_word_serializer.sv
// hk_word_serializer: emits a loaded 32-bit word as 4 little-endian bytes over valid/ready.
module hk_word_serializer
  import hk_pkg::*;
(
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        last,
  input  logic        clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        word_done
);
  logic [31:0] word_q;
  logic        last_q;
  logic [1:0]  idx;
  logic [1:0]  idx_n;
  assign idx_n = idx + 2'd1;
  assign word_done = out_valid && out_ready && idx == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      word_q    <= '0;
      last_q    <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      word_q    <= word;
      last_q    <= last;
      idx       <= '0;
      out_valid <= 1'b1;
      out_data  <= word[7:0];
      out_last  <= 1'b0;
    end else if (word_done) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (out_valid && out_ready) begin
      idx      <= idx_n;
      out_data <= 8'(word_q >> {idx_n, 3'b000});
      out_last <= last_q && idx_n == 2'(BYTES_PER_WORD - 1);
    end
  end
endmodule

// File: rtl/hk_sram_dump.sv
// hk_sram_dump: reads consecutive words from the management SRAM read-only port
// and streams them out as little-endian bytes.
module hk_sram_dump
  import hk_pkg::*;
#(
  parameter int ADDR_W = $clog2(SRAM_WORDS),
  parameter int RD_LAT = 1
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              abort,
  output logic              sram_ro_clk,
  output logic              sram_ro_csb,
  output logic [ADDR_W-1:0] sram_ro_addr,
  input  logic [31:0]       sram_ro_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  hk_state_t         state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W:0]   rem;
  logic [1:0]        lat_cnt;
  logic              zero_done;
  logic              load;
  logic              clear;
  logic              word_done;
  logic              last_word;
  assign sram_ro_clk  = core_clk;
  assign sram_ro_csb  = state != REQ;
  assign sram_ro_addr = cur_addr;
  assign cmd_ready    = state == IDLE;
  assign busy         = !cmd_ready;
  assign done         = state == DONE || zero_done;
  assign last_word    = rem == (ADDR_W + 1)'(1);
  assign load         = state == WAIT && lat_cnt == '0 && !abort;
  // Abort takes priority over everything except a dump that is already winding down in DONE.
  assign clear        = abort && (state == REQ || state == WAIT || state == EMIT);
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      rem       <= '0;
      lat_cnt   <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= cmd_ready && cmd_valid && cmd_len == '0;
      if (clear) state <= DONE;
      else case (state)
        IDLE: if (cmd_valid) begin
          cur_addr <= cmd_addr;
          rem      <= cmd_len;
          state    <= cmd_len == '0 ? IDLE : REQ;
        end
        REQ: begin
          lat_cnt <= 2'(RD_LAT - 1);
          state   <= WAIT;
        end
        WAIT: if (load) state <= EMIT;
              else lat_cnt <= lat_cnt - 1'b1;
        EMIT: if (word_done) begin
          state <= last_word ? DONE : REQ;
          if (!last_word) begin
            cur_addr <= cur_addr + 1'b1;
            rem      <= rem - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  hk_word_serializer u_ser (
    .core_clk  (core_clk),
    .core_rst  (core_rst),
    .load      (load),
    .word      (sram_ro_data),
    .last      (last_word),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .word_done (word_done)
  );
endmodule

// File: tb/tb_hk_sram_dump.sv
// tb_hk_sram_dump: table-driven dump scenarios against a latency-accurate SRAM model.
module tb_hk_sram_dump;
  parameter int RD_LAT = 1;
  localparam int AW = 8;
  logic          core_clk = 1'b0;
  logic          core_rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic          abort = 1'b0;
  logic          sram_ro_clk;
  logic          sram_ro_csb;
  logic [AW-1:0] sram_ro_addr;
  logic [31:0]   sram_ro_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  always #5 core_clk = ~core_clk;

  hk_sram_dump #(.ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
    .core_clk(core_clk), .core_rst(core_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .abort(abort), .sram_ro_clk(sram_ro_clk),
    .sram_ro_csb(sram_ro_csb), .sram_ro_addr(sram_ro_addr), .sram_ro_data(sram_ro_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  // SRAM model: captures on the csb-low edge, data visible RD_LAT edges later; garbage otherwise
  logic [31:0] mem [256];
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge sram_ro_clk) begin
    rd_pipe[0] <= sram_ro_csb ? 32'hDEAD_BEEF : mem[sram_ro_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_ro_data = rd_pipe[RD_LAT-1];

  typedef struct {
    string      nm;
    logic [7:0] addr;
    logic [8:0] len;
    int         rdy_pct;
    int         abort_at;
    int         exp_csb;
    int         exp_bytes;
  } vec_t;

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  logic [7:0] got[$];
  logic [7:0] csb_addr[$];
  int hs_cnt, csb_cnt, done_cnt, done_cyc, first_v, last_hs, last_cnt, last_pos, busy_gap, stall_err;
  logic prev_stall, prev_abort, prev_last, in_dump;
  logic [7:0] prev_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    got.delete(); csb_addr.delete();
    hs_cnt = 0; csb_cnt = 0; done_cnt = 0; done_cyc = -1; first_v = -1; last_hs = -1;
    last_cnt = 0; last_pos = -1; busy_gap = 0; stall_err = 0;
    prev_stall = 0; prev_abort = 0; prev_last = 0; prev_data = 0; in_dump = 0;
  endtask

  task automatic sample();
    if (!sram_ro_csb) begin csb_cnt++; csb_addr.push_back(sram_ro_addr); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (in_dump && done_cnt == 0 && (!busy || cmd_ready)) busy_gap++;
    if (out_valid && first_v < 0) first_v = cyc;
    if (prev_stall && !prev_abort && (!out_valid || out_data !== prev_data || out_last !== prev_last)) stall_err++;
    if (prev_abort) begin
      chk("abort_valid_drop", {31'b0, out_valid}, 0);
      chk("abort_csb_high", {31'b0, sram_ro_csb}, 1);
      chk("abort_done_pulse", {31'b0, done}, 1);
    end
    if (out_valid && out_ready) begin
      got.push_back(out_data);
      hs_cnt++;
      last_hs = cyc + 1;
      if (out_last) begin last_cnt++; last_pos = hs_cnt - 1; end
    end
    prev_stall = out_valid && !out_ready;
    prev_data = out_data;
    prev_last = out_last;
    prev_abort = abort;
  endtask

  // Sample on the falling edge, then drive #1 after the rising edge.
  task automatic step();
    @(negedge core_clk);
    sample();
    @(posedge core_clk);
    cyc++;
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_csb"}, {31'b0, sram_ro_csb}, 1);
    chk({tag, "_addr"}, {24'b0, sram_ro_addr}, 0);
    chk({tag, "_valid"}, {31'b0, out_valid}, 0);
    chk({tag, "_data"}, {24'b0, out_data}, 0);
    chk({tag, "_last"}, {31'b0, out_last}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
    chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 1);
  endtask

  task automatic run_dump(input vec_t v);
    int acc, ab_cyc, bad, w;
    logic aborted;
    logic [31:0] m;
    logic [7:0] eb, ea;
    clear_stats();
    aborted = 0; ab_cyc = -1;
    chk({v.nm, "_cmd_ready"}, {31'b0, cmd_ready}, 1);
    cmd_addr = v.addr; cmd_len = v.len; cmd_valid = 1;
    step();
    acc = cyc;
    in_dump = 1;
    cmd_addr = 8'h77; cmd_len = 9'd1;
    for (int t = 0; t < 3000 && done_cnt == 0; t++) begin
      cmd_valid = busy && !done;
      out_ready = $urandom_range(99) < v.rdy_pct;
      if (v.abort_at >= 0 && !aborted && hs_cnt == v.abort_at) begin
        abort = 1; out_ready = 0; aborted = 1; ab_cyc = cyc;
      end
      step();
      abort = 0;
    end
    cmd_valid = 0; out_ready = 1;
    repeat (4) step();
    chk({v.nm, "_done_cnt"}, done_cnt, 1);
    chk({v.nm, "_byte_cnt"}, got.size(), v.exp_bytes);
    bad = 0;
    for (int i = 0; i < got.size() && i < v.exp_bytes; i++) begin
      w = i / 4;
      ea = v.addr + 8'(w);
      m = mem[ea];
      eb = m[8*(i%4) +: 8];
      if (got[i] !== eb) bad++;
    end
    chk({v.nm, "_byte_errs"}, bad, 0);
    chk({v.nm, "_csb_cnt"}, csb_cnt, v.exp_csb);
    bad = 0;
    for (int k = 0; k < csb_addr.size(); k++) if (csb_addr[k] !== v.addr + 8'(k)) bad++;
    chk({v.nm, "_csb_addr_errs"}, bad, 0);
    if (v.len == 0) begin
      chk({v.nm, "_done_lat"}, done_cyc, acc);
      chk({v.nm, "_no_valid"}, first_v, -1);
    end else begin
      chk({v.nm, "_first_lat"}, first_v - acc, RD_LAT + 1);
      chk({v.nm, "_busy_gap"}, busy_gap, 0);
      chk({v.nm, "_stall_errs"}, stall_err, 0);
      if (v.abort_at >= 0) begin
        chk({v.nm, "_done_lat"}, done_cyc, ab_cyc + 1);
        chk({v.nm, "_last_cnt"}, last_cnt, 0);
      end else begin
        chk({v.nm, "_done_lat"}, done_cyc, last_hs);
        chk({v.nm, "_last_cnt"}, last_cnt, 1);
        chk({v.nm, "_last_pos"}, last_pos, 4 * v.len - 1);
      end
    end
    chk({v.nm, "_idle_ready"}, {31'b0, cmd_ready}, 1);
    chk({v.nm, "_idle_busy"}, {31'b0, busy}, 0);
  endtask

  vec_t vecs[8];
  vec_t after_rst;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'h5A, 8'(i) + 8'h40, ~8'(i), 8'(i)};
    mem[8'h10] = 32'hA1B2_C3D4;
    vecs[0] = '{"single",    8'h10, 9'd1,   100, -1, 1,   4};
    vecs[1] = '{"wrap",      8'hFE, 9'd4,   100, -1, 4,   16};
    vecs[2] = '{"bp30",      8'h20, 9'd2,   30,  -1, 2,   8};
    vecs[3] = '{"bp60_wrap", 8'hFF, 9'd3,   60,  -1, 3,   12};
    vecs[4] = '{"abort",     8'h00, 9'd256, 100, 5,  2,   5};
    vecs[5] = '{"abort_req", 8'h80, 9'd4,   100, 8,  3,   8};
    vecs[6] = '{"zero_len",  8'h40, 9'd0,   100, -1, 0,   0};
    vecs[7] = '{"full",      8'h33, 9'd256, 100, -1, 256, 1024};
    after_rst = '{"after_rst", 8'h05, 9'd2, 50, -1, 2, 8};
    #1 core_rst = 1;
    #1 check_reset("reset");
    repeat (2) @(posedge core_clk);
    #1 core_rst = 0;
    foreach (vecs[i]) run_dump(vecs[i]);
    // Reset in the middle of EMIT must drop everything without a done pulse.
    clear_stats();
    cmd_addr = 8'h50; cmd_len = 9'd3; cmd_valid = 1;
    step();
    cmd_valid = 0; out_ready = 1;
    for (int t = 0; t < 50 && hs_cnt < 2; t++) step();
    chk("rst_in_emit", {31'b0, out_valid}, 1);
    core_rst = 1;
    #1 check_reset("rst_mid");
    step(); step();
    core_rst = 0;
    repeat (3) step();
    chk("rst_no_done", done_cnt, 0);
    chk("rst_csb_cnt", csb_cnt, 1);
    run_dump(after_rst);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
